// File: rtl/truth_table_sweeper_pkg.sv
// Purpose: shared types and constants for the truth-table sweeper block.
// Latency: n/a (declarations only).
// Backpressure: n/a.
// Contents: FSM state enum, input/table widths, row-to-bit mapping helper.
package truth_table_sweeper_pkg;

  localparam int NUM_IN = 3;  // inputs of the downstream gate
  localparam int TT_W   = 8;  // truth-table code width (2**NUM_IN)

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Row 000 lands in the MSB so the captured code reads like the gate's hex name.
  function automatic logic [NUM_IN-1:0] tt_bit_idx(input logic [NUM_IN-1:0] k);
    return NUM_IN'(TT_W - 1) - k;
  endfunction

endpackage

// File: rtl/truth_table_sweeper_dwell_timer.sv
// Purpose: loadable dwell counter; flags the last cycle a vector is held.
// Latency: last_o is combinational from the registered count (internal use only).
// Backpressure: none; advances whenever adv_i is high, load_i has priority.
// Ports: clk/rst, load_i + dwell_i (latch dwell, clear count), adv_i (count), last_o.
module sweep_dwell_timer #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DWELL_W-1:0] dwell_i,
  input  logic               adv_i,
  output logic               last_o
);

  logic [DWELL_W-1:0] dwell_q;
  logic [DWELL_W-1:0] cnt_q;

  // Compare against the latched dwell rather than waiting for overflow, so an
  // all-ones dwell runs the full 2**DWELL_W cycles without an early wrap.
  assign last_o = (cnt_q == dwell_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      dwell_q <= '0;
      cnt_q   <= '0;
    end else if (load_i) begin
      dwell_q <= dwell_i;
      cnt_q   <= '0;
    end else if (adv_i) begin
      cnt_q <= last_o ? '0 : cnt_q + DWELL_W'(1);
    end
  end

endmodule

// File: rtl/truth_table_sweeper.sv
// Purpose: walks a 3-input gate through all 8 rows and captures its truth-table code.
// Latency: 8*(dwell+1) cycles from the start edge to the one-cycle done pulse.
// Backpressure: none; start ignored while busy/done, abort cancels a sweep.
// Ports: clk, rst (sync, active-high), start, abort, dwell, expected -> in1..in3
//        stimulus; out_sample <- gate; busy, done, tt_word, match (all registered).
module truth_table_sweeper
  import truth_table_sweeper_pkg::*;
#(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               abort,
  input  logic [DWELL_W-1:0] dwell,
  input  logic [TT_W-1:0]    expected,
  output logic               in1,
  output logic               in2,
  output logic               in3,
  input  logic               out_sample,
  output logic               busy,
  output logic               done,
  output logic [TT_W-1:0]    tt_word,
  output logic               match
);

  state_t              state_q;
  logic [NUM_IN-1:0]   k_q;
  logic [NUM_IN-1:0]   k_d;
  logic [NUM_IN-1:0]   in_q;
  logic [TT_W-1:0]     shadow_q;
  logic [TT_W-1:0]     shadow_d;
  logic [TT_W-1:0]     tt_word_q;
  logic                match_q;
  logic                busy_q;
  logic                done_q;

  logic                tmr_load;
  logic                tmr_adv;
  logic                tmr_last;

  assign tmr_load = (state_q == ST_IDLE) && start;
  assign tmr_adv  = (state_q == ST_DRIVE) && !abort;

  sweep_dwell_timer #(
    .DWELL_W (DWELL_W)
  ) u_timer (
    .clk     (clk),
    .rst     (rst),
    .load_i  (tmr_load),
    .dwell_i (dwell),
    .adv_i   (tmr_adv),
    .last_o  (tmr_last)
  );

  assign k_d = k_q + NUM_IN'(1);

  // Shadow with the current row's sample merged in, so the final row is
  // already included when tt_word/match are loaded on the DONE transition.
  always_comb begin
    shadow_d = shadow_q;
    shadow_d[tt_bit_idx(k_q)] = out_sample;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      k_q       <= '0;
      in_q      <= '0;
      shadow_q  <= '0;
      tt_word_q <= '0;
      match_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q  <= ST_DRIVE;
            k_q      <= '0;
            in_q     <= '0;
            shadow_q <= '0;
            busy_q   <= 1'b1;
          end
        end
        ST_DRIVE: begin
          // Abort is checked first so it also beats a coincident final capture.
          if (abort) begin
            state_q <= ST_IDLE;
            k_q     <= '0;
            in_q    <= '0;
            busy_q  <= 1'b0;
          end else if (tmr_last) begin
            shadow_q <= shadow_d;
            if (k_q == '1) begin
              state_q   <= ST_DONE;
              k_q       <= '0;
              in_q      <= '0;
              busy_q    <= 1'b0;
              done_q    <= 1'b1;
              tt_word_q <= shadow_d;
              match_q   <= (shadow_d == expected);
            end else begin
              k_q  <= k_d;
              in_q <= k_d;
            end
          end
        end
        ST_DONE: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign in1     = in_q[2];
  assign in2     = in_q[1];
  assign in3     = in_q[0];
  assign busy    = busy_q;
  assign done    = done_q;
  assign tt_word = tt_word_q;
  assign match   = match_q;

endmodule

// File: tb/tb_truth_table_sweeper.sv
// Purpose: self-checking bench for truth_table_sweeper (table vectors + corner sequences).
// Latency: n/a.
// Backpressure: n/a.
module tb_truth_table_sweeper;

  logic       clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, abort;
  logic [7:0] dwell, expected;
  logic       in1, in2, in3, out_sample, busy, done, match;
  logic [7:0] tt_word;

  logic       start2, abort2;
  logic [1:0] dwell2;
  logic [7:0] expected2;
  logic       in1b, in2b, in3b, out_sample2, busy2, done2, match2;
  logic [7:0] tt_word2;

  // Downstream gate model: mode 0 = function given by model_code, 1 = const 1, 2 = const 0.
  logic [7:0] model_code;
  logic [1:0] model_mode;
  logic [2:0] idx, idx2;
  assign idx  = {in1, in2, in3};
  assign idx2 = {in1b, in2b, in3b};

  always_comb begin
    out_sample = model_code[3'd7 - idx];
    if (model_mode == 2'd1) out_sample = 1'b1;
    if (model_mode == 2'd2) out_sample = 1'b0;
    out_sample2 = model_code[3'd7 - idx2];
  end

  truth_table_sweeper #(.DWELL_W(8)) u_dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .dwell(dwell),
    .expected(expected), .in1(in1), .in2(in2), .in3(in3),
    .out_sample(out_sample), .busy(busy), .done(done),
    .tt_word(tt_word), .match(match)
  );

  truth_table_sweeper #(.DWELL_W(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .abort(abort2), .dwell(dwell2),
    .expected(expected2), .in1(in1b), .in2(in2b), .in3(in3b),
    .out_sample(out_sample2), .busy(busy2), .done(done2),
    .tt_word(tt_word2), .match(match2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Starts a sweep and waits for done; lat = edges from the start edge to done.
  task automatic run_sweep(input logic [7:0] dw, input logic [7:0] ex,
                           output int lat, output int seq_err);
    int hold;
    hold = int'(dw) + 1;
    @(negedge clk); dwell = dw; expected = ex; start = 1'b1;
    @(negedge clk); start = 1'b0;
    lat = 0; seq_err = 0;
    while (!done && lat < 4000) begin
      if (busy !== 1'b1 || idx !== 3'(lat / hold)) seq_err++;
      @(negedge clk); lat++;
    end
  endtask

  // Waits (bounded) until the DUT drives vector v.
  task automatic wait_vec(input logic [2:0] v);
    int n;
    n = 0;
    while (idx !== v && n < 100) begin @(negedge clk); n++; end
  endtask

  typedef struct {
    logic [7:0] dwell;
    logic [7:0] code;
    logic [7:0] expected;
    logic [7:0] exp_tt;
    logic       exp_match;
    int         exp_lat;
  } vec_t;

  vec_t vecs[5];
  int   lat, seq_err, dcount, dcyc;

  initial begin
    vecs[0] = '{8'd0,   8'hE2, 8'hE2, 8'hE2, 1'b1, 8};
    vecs[1] = '{8'd3,   8'hE2, 8'hE3, 8'hE2, 1'b0, 32};
    vecs[2] = '{8'd1,   8'h1B, 8'h1B, 8'h1B, 1'b1, 16};
    vecs[3] = '{8'd255, 8'h80, 8'h80, 8'h80, 1'b1, 2048};
    vecs[4] = '{8'd2,   8'h01, 8'h00, 8'h01, 1'b0, 24};

    // Reset held with start also high: reset must win.
    rst = 1'b1; start = 1'b1; abort = 1'b0; dwell = 8'd0; expected = 8'h00;
    start2 = 1'b0; abort2 = 1'b0; dwell2 = 2'd0; expected2 = 8'hE2;
    model_code = 8'hE2; model_mode = 2'd0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_tt", tt_word, 8'h00);
    check("rst_match", match, 1'b0);
    check("rst_in", idx, 3'b000);
    rst = 1'b0; start = 1'b0;

    for (int i = 0; i < 5; i++) begin
      model_code = vecs[i].code;
      run_sweep(vecs[i].dwell, vecs[i].expected, lat, seq_err);
      check($sformatf("v%0d_lat", i), lat, vecs[i].exp_lat);
      check($sformatf("v%0d_seq", i), seq_err, 0);
      check($sformatf("v%0d_tt", i), tt_word, vecs[i].exp_tt);
      check($sformatf("v%0d_match", i), match, vecs[i].exp_match);
      @(negedge clk);
      check($sformatf("v%0d_done_1cyc", i), done, 1'b0);
      check($sformatf("v%0d_tt_hold", i), tt_word, vecs[i].exp_tt);
    end

    // Completed E2 sweep, then an aborted sweep with the gate stuck at 1.
    model_code = 8'hE2; model_mode = 2'd0;
    run_sweep(8'd0, 8'hE2, lat, seq_err);
    check("pre_abort_tt", tt_word, 8'hE2);
    model_mode = 2'd1;
    @(negedge clk); dwell = 8'd0; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_vec(3'd5);
    check("abort_at_v5", idx, 3'd5);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("abort_in", idx, 3'b000);
    check("abort_busy", busy, 1'b0);
    dcount = 0;
    repeat (20) begin if (done) dcount++; @(negedge clk); end
    check("abort_no_done", dcount, 0);
    check("abort_tt", tt_word, 8'hE2);
    check("abort_match", match, 1'b1);

    // Abort on the very cycle of the final capture.
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_vec(3'd7);
    check("abort_last_v7", idx, 3'd7);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    dcount = 0;
    repeat (10) begin if (done) dcount++; @(negedge clk); end
    check("abort_last_no_done", dcount, 0);
    check("abort_last_tt", tt_word, 8'hE2);

    // Reset mid-sweep at vector 4.
    @(negedge clk); dwell = 8'd1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    wait_vec(3'd4);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("mrst_busy", busy, 1'b0);
    check("mrst_in", idx, 3'b000);
    check("mrst_tt", tt_word, 8'h00);
    check("mrst_match", match, 1'b0);
    check("mrst_done", done, 1'b0);
    dcount = 0;
    repeat (20) begin if (done) dcount++; @(negedge clk); end
    check("mrst_no_done", dcount, 0);
    model_mode = 2'd2;
    run_sweep(8'd0, 8'h00, lat, seq_err);
    check("zero_lat", lat, 8);
    check("zero_tt", tt_word, 8'h00);
    check("zero_match", match, 1'b1);

    // start re-pulsed and dwell changed mid-sweep: timing must follow the latched dwell.
    model_mode = 2'd0; model_code = 8'hE2;
    @(negedge clk); dwell = 8'd1; expected = 8'hE2; start = 1'b1;
    @(negedge clk); start = 1'b0;
    dcount = 0; dcyc = -1;
    for (int c = 0; c < 40; c++) begin
      if (done) begin dcount++; if (dcyc < 0) dcyc = c; end
      if (c == 5) begin start = 1'b1; dwell = 8'd7; end
      else start = 1'b0;
      @(negedge clk);
    end
    check("restart_done_cnt", dcount, 1);
    check("restart_done_cyc", dcyc, 16);
    check("restart_tt", tt_word, 8'hE2);

    // Narrow dwell counter at all-ones: 4 cycles per vector, no early wrap.
    @(negedge clk); dwell2 = 2'b11; start2 = 1'b1;
    @(negedge clk); start2 = 1'b0;
    lat = 0; seq_err = 0;
    while (!done2 && lat < 200) begin
      if (busy2 !== 1'b1 || idx2 !== 3'(lat / 4)) seq_err++;
      @(negedge clk); lat++;
    end
    check("w2_lat", lat, 32);
    check("w2_seq", seq_err, 0);
    check("w2_tt", tt_word2, 8'hE2);
    check("w2_match", match2, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
